// File: rtl/i2s_master_tx.sv
// rtl/i2s_master_tx.sv - I2S bus master transmitter
// Derives BCK/WS from MCK and shifts out one stereo frame per WS period.
module i2s_master_tx #(
  parameter int c_DATA_NBITS = 24,
  parameter int P_BCK_HALF   = 2
) (
  input  logic                    i_mck,
  input  logic                    i_rstn,
  input  logic [c_DATA_NBITS-1:0] i_l,
  input  logic [c_DATA_NBITS-1:0] i_r,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic                    o_bck,
  output logic                    o_ws,
  output logic                    o_sdo,
  output logic                    o_frame_start,
  output logic                    o_underrun
);

  localparam int CW = (P_BCK_HALF > 1) ? $clog2(P_BCK_HALF) : 1;
  localparam int PAD = 32 - c_DATA_NBITS;
  localparam logic [CW-1:0] DIV_LAST = CW'(P_BCK_HALF - 1);

  logic [CW-1:0]           div_cnt;
  logic [5:0]              bit_cnt;
  logic [63:0]             shifter;
  logic [c_DATA_NBITS-1:0] hold_l;
  logic [c_DATA_NBITS-1:0] hold_r;
  logic [31:0]             slot_l;
  logic [31:0]             slot_r;
  logic [63:0]             frame;
  logic                    full;
  logic                    div_wrap;
  logic                    rise;
  logic                    frame_edge;
  logic                    accept;
  logic                    take;

  // The holding register is full exactly when it refuses new pairs.
  assign full       = ~o_ready;
  assign div_wrap   = (div_cnt == DIV_LAST);
  assign rise       = div_wrap && !o_bck;
  assign frame_edge = rise && (bit_cnt == 6'd0);
  assign accept     = i_valid && o_ready;
  assign take       = frame_edge && full;
  assign slot_l     = 32'(hold_l) << PAD;
  assign slot_r     = 32'(hold_r) << PAD;
  assign frame      = {slot_l, slot_r};

  always_ff @(posedge i_mck) begin
    if (!i_rstn) begin
      div_cnt       <= '0;
      bit_cnt       <= '0;
      shifter       <= '0;
      hold_l        <= '0;
      hold_r        <= '0;
      o_ready       <= 1'b1;
      o_bck         <= 1'b0;
      o_ws          <= 1'b0;
      o_sdo         <= 1'b0;
      o_frame_start <= 1'b0;
      o_underrun    <= 1'b0;
    end else begin
      o_frame_start <= 1'b0;
      o_underrun    <= 1'b0;
      div_cnt       <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) o_bck <= ~o_bck;

      // WS and the slot MSB change together on the BCK rising edge.
      if (rise) begin
        bit_cnt <= bit_cnt + 6'd1;
        o_ws    <= bit_cnt[5];
        if (frame_edge) begin
          o_frame_start <= 1'b1;
          if (full) begin
            o_sdo   <= frame[63];
            shifter <= {frame[62:0], 1'b0};
          end else begin
            o_sdo      <= 1'b0;
            shifter    <= '0;
            o_underrun <= 1'b1;
          end
        end else begin
          o_sdo   <= shifter[63];
          shifter <= {shifter[62:0], 1'b0};
        end
      end

      // accept and take are exclusive: accept needs the register empty.
      if (accept) begin
        hold_l  <= i_l;
        hold_r  <= i_r;
        o_ready <= 1'b0;
      end else if (take) begin
        o_ready <= 1'b1;
      end
    end
  end

endmodule

// File: doc/i2s_master_tx.md
Name: i2s_master_tx

Overview:
- I2S bus master transmitter: derives BCK and WS from MCK and serializes one stereo frame of signed samples per WS period on a single data line.
- Drives external DACs and amplifiers directly, and drives the team's I2S slave receiver in loopback benches.
- Samples enter through a valid/ready handshake into a one-deep holding register. They are transferred to the frame shifter at each frame start.

Parameters:
- c_DATA_NBITS, 24, sample width; must be 16..32. Samples are MSB-aligned in a 32-bit slot and zero-padded below.
- P_BCK_HALF, 2, MCK cycles per BCK half-period; must be >=1. The default gives MCK = 256fs and BCK = 64fs.

Ports:
- i_mck  in  1  master clock; all logic on its rising edge.
- i_rstn  in  1  reset; synchronous, active-low.
- i_l  in  c_DATA_NBITS  signed left sample.
- i_r  in  c_DATA_NBITS  signed right sample.
- i_valid  in  1  i_l and i_r hold a valid sample pair.
- o_ready  out  1  holding register empty; the pair is accepted when i_valid && o_ready.
- o_bck  out  1  bit clock.
- o_ws  out  1  word select; 0 = left slot, 1 = right slot.
- o_sdo  out  1  serial data, MSB first.
- o_frame_start  out  1  one-MCK pulse when slot bit 0 of the left channel is driven.
- o_underrun  out  1  one-MCK pulse when a frame starts with the holding register empty.

Behaviour:
- Reset values (i_rstn=0 at an i_mck edge):
  - o_bck=0, o_ws=0, o_sdo=0, o_frame_start=0, o_underrun=0, o_ready=1.
  - Divider count=0, bit count=0, holding register empty, 64-bit shifter=0.
  - Reset applied mid-frame aborts the frame immediately. The holding contents are discarded.
- Divider:
  - Count runs 0..P_BCK_HALF-1. At count==P_BCK_HALF-1, o_bck toggles and the count wraps to 0.
  - A 0->1 toggle is a "rise event", a 1->0 toggle is a "fall event".
  - The first rise event occurs on the P_BCK_HALF-th i_mck edge after reset is released.
- Bit counter:
  - 6 bits (0..63), advances by 1 on every rise event and wraps 63->0.
  - Slots 0..31 are left, 32..63 right.
- On each rise event with current bit count n:
  - o_ws <= n[5].
  - o_sdo <= shifter[63]; the shifter shifts left by 1 with 0 fill.
  - Exception, n==0 (frame start):
    - If the holding register is full: o_sdo <= {l,pad}[31] and the shifter gets {l,pad,r,pad} shifted by 1. The holding register empties.
    - If it is empty: the frame is all zeros and o_underrun pulses.
  - o_frame_start pulses on every n==0 rise event.
- Alignment:
  - WS and MSB change on the same BCK rising edge, with no one-bit delay.
  - Data and WS are stable across the BCK falling edge, where the team's slave samples.
- Fall events change only o_bck.
- Holding register:
  - o_ready = ~full, registered.
  - Accept on i_valid && o_ready. o_ready drops on the next edge.
  - A pair accepted in the same cycle as a frame-start rise event with the holding register empty goes to the holding register for the next frame. The current frame still underruns.
  - Full at frame start and a new pair is offered: not accepted that cycle, because o_ready=0. The pair is accepted on the following cycle.
- Padding: pad = (32 - c_DATA_NBITS) zeros. When c_DATA_NBITS==32, no padding.
- Steady state: frame period = 64*2*P_BCK_HALF MCK cycles, exactly; no jitter.

Test Plan:
- Reset value check: hold i_rstn=0 for 10 cycles -> all outputs at reset values.
- Clock ratio (P_BCK_HALF=2): release reset -> o_bck period 4 MCK, o_ws period 256 MCK, 50% duty.
  - o_frame_start every 256 MCK; first at MCK edge 2 after release.
- Single frame:
  - Stimulus: push l=24'h800001, r=24'h7FFFFE before the first frame start.
  - Serial bits sampled at BCK falling edges, left slot: 32'h80000100.
  - Right slot: 32'h7FFFFE00, o_ws=1 for slots 32..63.
  - Loopback into the team's I2S slave returns the same pair.
- Underrun: no push after reset -> first frame all-zero o_sdo with o_underrun pulse.
  - Push during frame 1 -> frame 2 carries that data, o_underrun=0.
- Backpressure: hold i_valid=1 with an incrementing pair each accept.
  - Exactly one accept per frame, one MCK after each o_frame_start.
  - Received sequence has no gaps or duplicates.
- Reset mid-frame: assert i_rstn=0 at slot 40 for 1 cycle.
  - Outputs return to reset values on that edge and the pending holding data is lost.
  - The next frame starts P_BCK_HALF MCK after release and underruns.
